// File: rtl/reset_sequencer.sv
// Orders reset release after DCM lock: ZBT RAM interface first, system logic STAGGER_CYCLES later.
// Optional `LOCK_LOSS_COUNT_EN adds a saturating lock_loss_count output.
module reset_sequencer #(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int LOST_FILTER    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       locked,
    output logic       ram_reset,
    output logic       sys_reset,
    output logic       ready
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0] lock_loss_count
`endif
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > STAGGER_CYCLES) ? SETTLE_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int FILT_W     = $clog2(LOST_FILTER + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_ONE     = FILT_W'(1);
    localparam logic [FILT_W-1:0] FILT_LAST    = FILT_W'(LOST_FILTER - 1);
    localparam logic              SETTLE_IS_1  = (SETTLE_CYCLES == 1);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_STAGGER   = 3'd3,
        ST_RUN       = 3'd4,
        ST_LOST      = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] r_lock_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [FILT_W-1:0]      r_filt;
    logic                   r_ram_reset;
    logic                   r_sys_reset;
    logic                   r_ready;

    logic                   w_locked_s;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [FILT_W-1:0]      w_filt_nxt;

    assign w_locked_s = r_lock_sync[SYNC_STAGES-1];

    function automatic logic ram_rst_for(input state_t s);
        return (s != ST_STAGGER) && (s != ST_RUN);
    endfunction

    function automatic logic sys_rst_for(input state_t s);
        return (s != ST_RUN);
    endfunction

    // The cycle that moves WAIT_LOCK to SETTLE already saw lock high, so it counts as the first settle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_filt_nxt  = '0;
        case (r_state)
            ST_HOLD: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
            ST_WAIT_LOCK: begin
                w_cnt_nxt = '0;
                if (w_locked_s) begin
                    if (SETTLE_IS_1) begin
                        w_state_nxt = ST_STAGGER;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_STAGGER;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STAGGER: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STAGGER_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (!w_locked_s) begin
                    if (r_filt == FILT_LAST) begin
                        w_state_nxt = ST_LOST;
                    end else begin
                        w_filt_nxt = r_filt + FILT_ONE;
                    end
                end
            end
            ST_LOST: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_sync <= '0;
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_filt      <= '0;
            r_ram_reset <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_filt      <= w_filt_nxt;
            r_ram_reset <= ram_rst_for(w_state_nxt);
            r_sys_reset <= sys_rst_for(w_state_nxt);
            r_ready     <= ~sys_rst_for(w_state_nxt);
        end
    end

    assign ram_reset = r_ram_reset;
    assign sys_reset = r_sys_reset;
    assign ready     = r_ready;

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] r_loss_cnt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= '0;
        end else if ((w_state_nxt == ST_LOST) && (r_state != ST_LOST)) begin
            r_loss_cnt <= sat_inc8(r_loss_cnt);
        end
    end

    assign lock_loss_count = r_loss_cnt;
`endif

endmodule
